// File: rtl/matmaxabs_pkg.sv
// Shared types and helpers for the matrix max-abs scanner and related matlib stages.
package matmaxabs_pkg;

  // Scanner control states; also exported on the debug state port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Fixed-point 1.0 for a given number of fractional bits.
  // Callers truncate the result to their own data width.
  function automatic logic [63:0] fx_one(input int unsigned scale);
    return 64'd1 << scale;
  endfunction

endpackage

// File: rtl/matmaxabs_seq_fx_abs_sat.sv
// Combinational saturating absolute value of a signed two's-complement word.
// The most negative code maps to the largest positive code, so the result
// always fits in WIDTH-1 bits and can be treated as unsigned.
module fx_abs_sat #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] y_o
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  // Pass non-negative values, negate negative ones, clamp the one code with no positive twin.
  always_comb begin
    y_o = x_i;
    if (x_i[WIDTH-1]) begin
      if (x_i == MOST_NEG) begin
        y_o = MOST_POS;
      end else begin
        y_o = -x_i;
      end
    end
  end

endmodule

// File: rtl/matmaxabs_seq.sv
// Sequential max-|a| scanner. Captures the whole matrix on an accepted start,
// then walks one element per clock in row-major order through a single
// saturating-abs unit and a single comparator. The result is the divisor for
// the unscale stage; an all-zero matrix yields fixed-point 1.0 with zero=1 so
// the downstream divide never sees zero.
//
// Fixed-point format is given by WIDTH (word size) and SCALE (fractional bits).
//
// Handshake: start is sampled only while the FSM is IDLE; starts seen in SCAN
// or DONE are dropped. busy is high from the accepting edge until the edge
// that raises done; done is a one-cycle pulse; f and zero hold until the next
// done or reset.
module matmaxabs_seq
  import matmaxabs_pkg::*;
#(
  parameter int ROWS  = 1,
  parameter int COLS  = 1,
  parameter int WIDTH = 32,
  parameter int SCALE = 16
) (
  input  logic                              clk,
  input  logic                              reset_l,
  input  logic                              start,
  input  logic [ROWS:1][COLS:1][WIDTH-1:0]  a,
  output logic                              busy,
  output logic                              done,
  output logic                              zero,
  output logic [WIDTH-1:0]                  f,
  output state_t                            dbg_state_o
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  // Shadow storage padded to a power of two so idx_q indexes it exactly.
  localparam int DEPTH = 1 << IDX_W;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [WIDTH-1:0] FX_ONE   = WIDTH'(fx_one(SCALE));

  state_t               state_q;
  logic [WIDTH-1:0]     shadow_q [DEPTH];
  logic [IDX_W-1:0]     idx_q;
  logic [WIDTH-1:0]     acc_q;
  logic [WIDTH-1:0]     acc_d;
  logic                 busy_q;
  logic                 done_q;
  logic                 zero_q;
  logic [WIDTH-1:0]     f_q;

  logic [N*WIDTH-1:0]   a_flat;
  logic [WIDTH-1:0]     elem;
  logic [WIDTH-1:0]     elem_abs;

  // Row-major flattening: element [1][1] sits in the lowest WIDTH bits.
  assign a_flat = a;

  // Current element of the captured matrix.
  assign elem = shadow_q[idx_q];

  fx_abs_sat #(
    .WIDTH (WIDTH)
  ) u_abs (
    .x_i (elem),
    .y_o (elem_abs)
  );

  // Running maximum including the current element; ties keep the same value.
  always_comb begin
    acc_d = acc_q;
    if (elem_abs > acc_q) begin
      acc_d = elem_abs;
    end
  end

  // Scan control: capture on start, accumulate in SCAN, publish result on the last element.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      f_q     <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < N; k++) begin
              shadow_q[k] <= a_flat[k*WIDTH +: WIDTH];
            end
            idx_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          acc_q <= acc_d;
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            if (acc_d == '0) begin
              f_q    <= FX_ONE;
              zero_q <= 1'b1;
            end else begin
              f_q    <= acc_d;
              zero_q <= 1'b0;
            end
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign zero        = zero_q;
  assign f           = f_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_matmaxabs_seq.sv
// Bench for matmaxabs_seq: three instances (2x2, 3x1, 1x1), directed vectors
// with hand-computed results. Drivers push expected {f, zero, done edge} into
// per-instance queues; monitors pop and compare on every done pulse.
module tb_matmaxabs_seq;
  import matmaxabs_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] f;
    logic         zero;
    int           done_edge;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_l = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- DUT signals ----------------
  logic          start2 = 1'b0, start3 = 1'b0, start1 = 1'b0;
  logic [127:0]  a2 = '0;
  logic [95:0]   a3 = '0;
  logic [31:0]   a1 = '0;
  logic          busy2, busy3, busy1;
  logic          done2, done3, done1;
  logic          zero2, zero3, zero1;
  logic [W-1:0]  f2, f3, f1;
  state_t        dbg2, dbg3, dbg1;

  exp_t q2[$];
  exp_t q3[$];
  exp_t q1[$];

  matmaxabs_seq #(.ROWS(2), .COLS(2), .WIDTH(W), .SCALE(16)) u_m22 (
    .clk(clk), .reset_l(reset_l), .start(start2), .a(a2),
    .busy(busy2), .done(done2), .zero(zero2), .f(f2), .dbg_state_o(dbg2)
  );

  matmaxabs_seq #(.ROWS(3), .COLS(1), .WIDTH(W), .SCALE(16)) u_m31 (
    .clk(clk), .reset_l(reset_l), .start(start3), .a(a3),
    .busy(busy3), .done(done3), .zero(zero3), .f(f3), .dbg_state_o(dbg3)
  );

  matmaxabs_seq #(.ROWS(1), .COLS(1), .WIDTH(W), .SCALE(16)) u_m11 (
    .clk(clk), .reset_l(reset_l), .start(start1), .a(a1),
    .busy(busy1), .done(done1), .zero(zero1), .f(f1), .dbg_state_o(dbg1)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int n_of(input int sel);
    case (sel)
      2:       return 4;
      3:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      2:       return busy2;
      3:       return busy3;
      default: return busy1;
    endcase
  endfunction

  task automatic drive_start(input int sel, input logic v);
    case (sel)
      2:       start2 = v;
      3:       start3 = v;
      default: start1 = v;
    endcase
  endtask

  task automatic drive_a(input int sel, input logic [127:0] m);
    case (sel)
      2:       a2 = m;
      3:       a3 = m[95:0];
      default: a1 = m[31:0];
    endcase
  endtask

  task automatic push_exp(input int sel, input exp_t e);
    case (sel)
      2:       q2.push_back(e);
      3:       q3.push_back(e);
      default: q1.push_back(e);
    endcase
  endtask

  task automatic wait_until_edge(input int target);
    int guard = 0;
    while (edge_cnt < target && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (edge_cnt != target) begin
      n_fail++;
      $display("FAIL wait_edge: at edge %0d required %0d", edge_cnt, target);
    end
  endtask

  // Called at a negedge with the selected instance idle. Returns at the
  // negedge of the IDLE cycle that follows DONE, so back-to-back calls
  // exercise the N+2 throughput.
  task automatic scan(input int sel, input logic [127:0] m,
                      input logic [W-1:0] ef, input logic ez);
    int k;
    int n = n_of(sel);
    drive_a(sel, m);
    drive_start(sel, 1'b1);
    @(negedge clk);
    drive_start(sel, 1'b0);
    k = edge_cnt;
    push_exp(sel, '{ef, ez, k + n});
    for (int i = 0; i < n; i++) begin
      check($sformatf("busy%0d_scan", sel), busy_of(sel), 1);
      @(negedge clk);
    end
    check($sformatf("busy%0d_at_done", sel), busy_of(sel), 0);
    @(negedge clk);
  endtask

  // ---------------- monitors / scoreboard ----------------
  exp_t e2, e3, e1;

  // 2x2 instance result checker.
  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL done2_unexpected: done at edge %0d, required no done", edge_cnt);
      end else begin
        e2 = q2.pop_front();
        check("f2", f2, e2.f);
        check("zero2", zero2, e2.zero);
        check("latency2_edge", edge_cnt, e2.done_edge);
      end
    end
  end

  // 3x1 instance result checker.
  always @(negedge clk) begin
    if (done3) begin
      if (q3.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL done3_unexpected: done at edge %0d, required no done", edge_cnt);
      end else begin
        e3 = q3.pop_front();
        check("f3", f3, e3.f);
        check("zero3", zero3, e3.zero);
        check("latency3_edge", edge_cnt, e3.done_edge);
      end
    end
  end

  // 1x1 instance result checker.
  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL done1_unexpected: done at edge %0d, required no done", edge_cnt);
      end else begin
        e1 = q1.pop_front();
        check("f1", f1, e1.f);
        check("zero1", zero1, e1.zero);
        check("latency1_edge", edge_cnt, e1.done_edge);
      end
    end
  end

  // Hard time limit.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;

    // Reset state
    @(negedge clk);
    check("rst_busy2", busy2, 0);
    check("rst_done2", done2, 0);
    check("rst_zero2", zero2, 0);
    check("rst_f2", f2, 0);
    check("rst_state2", dbg2, IDLE);
    check("rst_f3", f3, 0);
    check("rst_f1", f1, 0);
    reset_l = 1'b1;
    @(negedge clk);

    // 2x2 mixed signs: abs = 1.0, 3.0, 0.5, 2.0 -> 3.0
    scan(2, {32'h00010000, 32'hFFFD0000, 32'h00008000, 32'h00020000}, 32'h00030000, 1'b0);
    // Back-to-back: most-negative saturates and ties with 0x7FFFFFFF
    scan(2, {32'hFFFFFFFE, 32'h80000000, 32'h7FFFFFFF, 32'h00000000}, 32'h7FFFFFFF, 1'b0);

    // 3x1 all zero -> 1.0 with zero flag
    scan(3, 128'h0, 32'h00010000, 1'b1);
    // 3x1 small values: |-1| ties with 1
    scan(3, {32'h0, 32'hFFFFFFFF, 32'h00000000, 32'h00000001}, 32'h00000001, 1'b0);

    // 1x1 most negative saturates
    scan(1, {96'h0, 32'h80000000}, 32'h7FFFFFFF, 1'b0);
    scan(1, {96'h0, 32'hFFFF0000}, 32'h00010000, 1'b0);
    scan(1, 128'h0, 32'h00010000, 1'b1);

    // Start during busy and during DONE is dropped; result reflects first capture
    a2 = {32'h00001234, 32'hFFFFF000, 32'h00000000, 32'h00000000};
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    k = edge_cnt;
    q2.push_back('{32'h00001234, 1'b0, k + 4});
    @(negedge clk);
    a2 = {32'h7FFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000};
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_until_edge(k + 4);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    check("ignored_start_busy2", busy2, 0);
    check("ignored_start_state2", dbg2, IDLE);

    // Reset during the second scan cycle aborts without a done
    a2 = {32'h00010000, 32'hFFFD0000, 32'h00008000, 32'h00020000};
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    reset_l = 1'b0;
    #1;
    check("abort_busy2", busy2, 0);
    check("abort_done2", done2, 0);
    check("abort_f2", f2, 0);
    check("abort_zero2", zero2, 0);
    check("abort_state2", dbg2, IDLE);
    @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);
    scan(2, {32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFF8000}, 32'h00008000, 1'b0);

    // start held high: two scans exactly N+2 = 6 edges apart
    a2 = {32'h00000010, 32'hFFFFFFF0, 32'h00000005, 32'hFFFFFFFF};
    start2 = 1'b1;
    @(negedge clk);
    k = edge_cnt;
    q2.push_back('{32'h00000010, 1'b0, k + 4});
    a2 = {32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFE0000};
    q2.push_back('{32'h00020000, 1'b0, k + 10});
    wait_until_edge(k + 6);
    start2 = 1'b0;
    check("held_second_busy2", busy2, 1);
    wait_until_edge(k + 12);

    // Drain and final accounting
    repeat (3) @(negedge clk);
    check("q2_drained", q2.size(), 0);
    check("q3_drained", q3.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matmaxabs_seq.md
Name: matmaxabs_seq

Overview:
Sequential scanner that finds the largest absolute value among the elements of a fixed-point matrix or vector. It produces the scalar divisor for the matrix unscale stage, which uses it to normalise the same matrix into [-1.0, 1.0].
It processes one element per clock, which keeps area to a single comparator regardless of matrix size.
It uses a start/done handshake and captures its input, so the upstream producer may change `a` after start is accepted.

Parameters:
ROWS, 1, number of matrix rows (1 for a row vector)
COLS, 1, number of matrix columns (1 for a column vector)

Ports:
clk  input  1  clock, all state updates on rising edge
reset_l  input  1  asynchronous active-low reset
g  interface  fixedp  fixed point parameters (g.WIDTH, g.SCALE) and common ports
start  input  1  request a scan; accepted only when busy=0
a  input  [ROWS:1][COLS:1][g.WIDTH-1:0]  signed two's-complement matrix, sampled on accepted start
busy  output  1  high from the edge after accepted start until the edge that raises done
done  output  1  one-cycle pulse, f valid and updated
zero  output  1  result flag, all captured elements were 0; held with f
f  output  [g.WIDTH-1:0]  max |a[i][j]|, or 1.0 when zero=1; held until next done

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, busy=0, done=0, zero=0, f=0, idx=0, acc=0. Reset mid-scan aborts the scan; no done is produced.
- N = ROWS*COLS. Scan order is row-major: [1][1], [1][2] ... [ROWS][COLS].
- States are IDLE, SCAN, DONE:
  - IDLE: on start=1 at an edge, capture a into a shadow register, set idx=0 and acc=0, go to SCAN, set busy=1.
  - SCAN: each edge sets acc=max(acc, abs_sat(shadow[idx])) and idx=idx+1.
    - On the edge processing idx=N-1: load f and zero, set done=1, set busy=0, go to DONE.
  - DONE: lasts one cycle. Next edge sets done=0 and goes to IDLE.
- start while busy=1 or in DONE is ignored (dropped, not queued).
- start in the IDLE cycle that immediately follows DONE is accepted normally, giving back-to-back throughput of N+2 cycles.
- Latency: done is high in the cycle beginning N edges after the edge that accepted start. N=1 gives done one cycle after acceptance.
- abs_sat: non-negative x passes unchanged. Negative x gives -x. The most negative code (1<<(WIDTH-1)) saturates to (1<<(WIDTH-1))-1. Result is unsigned but always fits in WIDTH-1 bits.
- Comparison is unsigned on abs values. Ties have no effect, since the value is identical.
- Zero guard: if final acc==0, then f = 1<<g.SCALE (fixed-point 1.0) and zero=1. This prevents divide-by-zero downstream. Otherwise zero=0 and f=acc.
- idx width is clog2(N), minimum 1. Its terminal compare is against N-1, so no wrap occurs inside SCAN.
- f and zero change only on the done edge or on reset.

Decomposition:
- Package matmaxabs_pkg holds:
  - state enum state_t {IDLE, SCAN, DONE}
  - function fx_one(scale) returning 1<<scale
- Sub-module fx_abs_sat is a combinational saturating absolute value, parameterised by WIDTH. It is instantiated once on the selected shadow element and is reusable by other matlib stages.
- Element select is a plain indexed read of the flattened shadow register.

Test Plan:
1. WIDTH=32, SCALE=16, ROWS=2, COLS=2, a={0x00010000, 0xFFFD0000, 0x00008000, 0x00020000}, start pulse -> busy for 4 cycles, done in cycle 4 after acceptance, f=0x00030000, zero=0.
2. All-zero 3x1 vector -> f=0x00010000, zero=1, done after 3 cycles.
3. Single element a=0x80000000 (ROWS=COLS=1) -> f=0x7FFFFFFF, done one cycle after acceptance.
4. Change a and pulse start again during busy -> second start ignored. f reflects the first captured matrix, exactly one done.
5. Deassert reset_l mid-scan (cycle 2 of 4) -> busy, done, f, zero return to 0 immediately. A later start completes normally with the correct f.
6. start held high continuously across two scans -> done pulses every N+2 cycles. Each f matches the a value present at its acceptance edge.
